// File: rtl/mul_pkg.sv
// mul_pkg: shared op/state types and op-to-signedness decode for iter_multiplier
package mul_pkg;
  typedef enum logic [1:0] {MUL, MULH, MULHSU, MULHU} mul_op_e;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} mul_state_e;
  // {a_signed, b_signed}
  function automatic logic [1:0] op_signed(mul_op_e op);
    return {op != MULHU, op == MUL || op == MULH};
  endfunction
endpackage

// File: rtl/mul_digit_acc.sv
// mul_digit_acc: one WIDTH x DIGIT partial product, shifted by step, added to the accumulator
module mul_digit_acc import mul_pkg::*; #(
  parameter int WIDTH = 64,
  parameter int DIGIT = 16,
  parameter int SW    = 2
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [DIGIT-1:0]   digit,
  input  logic [SW-1:0]      step,
  input  logic [2*WIDTH-1:0] acc_in,
  output logic [2*WIDTH-1:0] acc_out
);
  logic [2*WIDTH-1:0] pp;
  always_comb begin
    pp = {{WIDTH{1'b0}}, a} * {{(2*WIDTH-DIGIT){1'b0}}, digit};
    acc_out = acc_in + (pp << (DIGIT * int'(step)));
  end
endmodule

// File: rtl/iter_multiplier.sv
// iter_multiplier: iterative DIGIT-bits-per-cycle multiplier for MUL/MULH/MULHSU/MULHU with tag passthrough
module iter_multiplier import mul_pkg::*; #(
  parameter int WIDTH = 64,
  parameter int DIGIT = 16,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag
);
  localparam int STEPS = WIDTH / DIGIT;
  localparam int SW = STEPS > 1 ? $clog2(STEPS) : 1;

  mul_state_e state, next;
  mul_op_e op;
  logic [SW-1:0] cnt;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [TAG_W-1:0] tag;
  logic [2*WIDTH-1:0] acc, acc_step, acc_fix;
  logic [1:0] sgn;
  logic neg, accept, last, a_neg, b_neg;

  mul_digit_acc #(.WIDTH(WIDTH), .DIGIT(DIGIT), .SW(SW)) u_acc (
    .a(mag_a),
    .digit(mag_b[DIGIT*int'(cnt) +: DIGIT]),
    .step(cnt),
    .acc_in(acc),
    .acc_out(acc_step)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;

  always_comb begin
    next = state;
    if (flush) next = IDLE;
    else if (accept) next = CALC;
    else if (state == CALC && last) next = FIX;
    else if (state == FIX) next = DONE;
    else if (state == DONE && out_ready) next = IDLE;
  end

  always_comb begin
    in_ready = !flush && (state == IDLE || (state == DONE && out_ready));
    out_valid = state == DONE;
    accept = in_valid && in_ready;
  end

  always_comb begin
    sgn = op_signed(mul_op_e'(in_op));
    a_neg = sgn[1] && in_a[WIDTH-1];
    b_neg = sgn[0] && in_b[WIDTH-1];
    last = cnt == SW'(STEPS - 1);
    acc_fix = neg ? -acc : acc;
  end

  // Magnitudes are taken at accept so CALC only ever multiplies unsigned values
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mag_a <= '0;
      mag_b <= '0;
      neg <= 1'b0;
      op <= MUL;
      tag <= '0;
      acc <= '0;
      cnt <= '0;
      out_result <= '0;
      out_tag <= '0;
    end else if (!flush) begin
      if (accept) begin
        mag_a <= a_neg ? -in_a : in_a;
        mag_b <= b_neg ? -in_b : in_b;
        neg <= a_neg ^ b_neg;
        op <= mul_op_e'(in_op);
        tag <= in_tag;
        acc <= '0;
        cnt <= '0;
      end else if (state == CALC) begin
        acc <= acc_step;
        cnt <= cnt + SW'(1);
      end else if (state == FIX) begin
        acc <= acc_fix;
        out_result <= op == MUL ? acc_fix[WIDTH-1:0] : acc_fix[2*WIDTH-1:WIDTH];
        out_tag <= tag;
      end
    end
endmodule
